wb_regfile: RTL

- Write-back end of the MEM/WB pipeline register: consumes the latched syscall/WE/RW/A/w fields and commits results into the 32x32 architectural register file.
- Provides two combinational read ports to ID, with a write-through bypass so ID sees same-cycle write-back data.
- Executes the syscall instruction in WB (halt / display) and counts retired instructions.

---
 rtl/wb_regfile.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage of the MEM/WB pipeline register.
// Commits results into the 32x32 architectural register file, serves two
// combinational ID read ports with write-through bypass, executes syscall
// (halt / display of $a0) and counts retired instructions.
// Optional build macro: WB_SYSCALL_COUNT_EN adds the saturating sys_count output.
module wb_regfile #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  HALT_CODE = 32'd10,
    parameter logic [DATA_W-1:0]  DISP_CODE = 32'd34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              syscall,
    input  logic              WE,
    input  logic [4:0]        RW,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] w,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic              halt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic [31:0]       retired
`ifdef WB_SYSCALL_COUNT_EN
    ,
    output logic [15:0]       sys_count
`endif
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [32];
    logic              commit;
    logic              accept;

    // A is carried only for interface symmetry with MEM/WB
    logic              unused_a;
    assign unused_a = ^A;

    // A WB slot is accepted only while running; commit additionally needs a real destination
    assign accept = go & (state == RUN);
    assign commit = accept & WE & (RW != 5'd0);

    // Architectural register file; register 0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[RW] <= w;
        end
    end

    // Read ports: $zero, then same-cycle write-back bypass, then stored value
    always_comb begin
        qa = regs[ra];
        qb = regs[rb];
        if (commit && (RW == ra)) qa = w;
        if (commit && (RW == rb)) qb = w;
        if (ra == 5'd0) qa = '0;
        if (rb == 5'd0) qb = '0;
    end

    // Run/halt FSM with syscall execution and retirement counters (registered outputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            halt       <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            retired    <= '0;
`ifdef WB_SYSCALL_COUNT_EN
            sys_count  <= '0;
`endif
        end else begin
            disp_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (go) begin
                        retired <= retired + 32'd1;
                        // Decisions read the stored (pre-write) $v0/$a0
                        if (syscall) begin
`ifdef WB_SYSCALL_COUNT_EN
                            if (sys_count != 16'hFFFF) sys_count <= sys_count + 16'd1;
`endif
                            if (regs[2] == HALT_CODE) begin
                                state <= HALTED;
                                halt  <= 1'b1;
                            end else if (regs[2] == DISP_CODE) begin
                                disp_data  <= regs[4];
                                disp_valid <= 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

endmodule
